// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 3;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IRD  = 2'd1,
    DRD  = 2'd2
  } resp_sel_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive cycles the fetch port asked but lost;
// fetch_win tells the grant mux to let fetch through.
module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  output logic fetch_win
);

  // STARVE_MAX of 0 still needs a one-bit register that simply stays at 0
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!i_req || i_gnt) begin
      cnt <= '0;
    end else if (cnt < MAX_C) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign fetch_win = (cnt >= MAX_C);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter: data port has priority, fetch wins after
// STARVE_MAX losses. Define MEM_ARB_PERF_EN to add stall/access counters.
module mips_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]       perf_i_stall,
  output logic [31:0]       perf_d_acc,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic      fetch_win;
  resp_sel_t resp_sel, resp_next;

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_gnt    (i_gnt),
    .fetch_win(fetch_win)
  );

  // Grants are suppressed during reset so no access leaks into the memory
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (d_req && !(i_req && fetch_win)) d_gnt = 1'b1;
      else if (i_req)                     i_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_en    = i_gnt || d_gnt;
    mem_we    = d_gnt && d_we;
    mem_addr  = d_gnt ? d_addr : i_addr;
    mem_wdata = d_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) resp_sel <= NONE;
    else     resp_sel <= resp_next;
  end

  always_comb begin
    resp_next = NONE;
    if (i_gnt)              resp_next = IRD;
    else if (d_gnt && !d_we) resp_next = DRD;
  end

  assign i_rvalid = (resp_sel == IRD);
  assign d_rvalid = (resp_sel == DRD);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i_stall <= '0;
      perf_d_acc   <= '0;
    end else begin
      if (i_req && !i_gnt) perf_i_stall <= perf_i_stall + 32'd1;
      if (d_gnt)           perf_d_acc   <= perf_d_acc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a behavioural 1024x32 memory;
// perf counters are checked when MEM_ARB_PERF_EN is defined.
module tb_mips_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [9:0]  i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_stall;
  logic [31:0] perf_d_acc;
`endif

  int vecCount = 0;
  int errCount = 0;

  logic [31:0] memData [1024];
  logic        memWritten [1024];

  mips_mem_arbiter #(
    .ADDR_W(10),
    .DATA_W(32),
    .STARVE_MAX(3)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
`ifdef MEM_ARB_PERF_EN
    .perf_i_stall(perf_i_stall),
    .perf_d_acc  (perf_d_acc),
`endif
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preloaded contents: a recognisable pattern, with the fetch test word at 5
  function automatic logic [31:0] preload(input int a);
    if (a == 5) return 32'hDEADBEEF;
    return 32'hA500_0000 | 32'(a);
  endfunction

  // Behavioural synchronous memory; unwritten words read as the preload pattern
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) memWritten[i] <= 1'b0;
    end else if (mem_en) begin
      if (mem_we) begin
        memData[mem_addr]    <= mem_wdata;
        memWritten[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= memWritten[mem_addr] ? memData[mem_addr] : preload(int'(mem_addr));
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [9:0] ia, input logic dr,
                               input logic dw, input logic [9:0] da,
                               input logic [31:0] dwd);
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  logic prevD;

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 10'd3, 1'b1, 1'b1, 10'd4, 32'h55);

    // Reset holds every grant and enable low even with both requests up
    @(negedge clk); #1;
    checkOutput("rst_i_gnt", 32'(i_gnt), 32'd0);
    checkOutput("rst_d_gnt", 32'(d_gnt), 32'd0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    checkOutput("rst_d_rvalid", 32'(d_rvalid), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    #1;
    checkOutput("idle_mem_en", 32'(mem_en), 32'd0);

    // Fetch only from address 5
    @(negedge clk);
    applyStimulus(1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'd0);
    #1;
    checkOutput("f_i_gnt", 32'(i_gnt), 32'd1);
    checkOutput("f_d_gnt", 32'(d_gnt), 32'd0);
    checkOutput("f_mem_en", 32'(mem_en), 32'd1);
    checkOutput("f_mem_we", 32'(mem_we), 32'd0);
    checkOutput("f_mem_addr", 32'(mem_addr), 32'd5);
    @(negedge clk);
    applyStimulus(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    #1;
    checkOutput("f_i_rvalid", 32'(i_rvalid), 32'd1);
    checkOutput("f_i_rdata", i_rdata, 32'hDEADBEEF);
    checkOutput("f_d_rvalid", 32'(d_rvalid), 32'd0);

    // Both ports load every cycle: expected grants D,D,D,I,D,D,D,I
    prevD = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      applyStimulus(1'b1, 10'd20, 1'b1, 1'b0, 10'(100 + k), 32'd0);
      #1;
      if (k > 0) begin
        checkOutput($sformatf("arb_d_rvalid%0d", k), 32'(d_rvalid), 32'(prevD));
        checkOutput($sformatf("arb_i_rvalid%0d", k), 32'(i_rvalid), 32'(!prevD));
        checkOutput($sformatf("arb_rdata%0d", k), prevD ? d_rdata : i_rdata,
                    prevD ? preload(100 + k - 1) : preload(20));
      end
      prevD = ((k % 4) != 3);
      checkOutput($sformatf("arb_d_gnt%0d", k), 32'(d_gnt), 32'(prevD));
      checkOutput($sformatf("arb_i_gnt%0d", k), 32'(i_gnt), 32'(!prevD));
      checkOutput($sformatf("arb_mem_addr%0d", k), 32'(mem_addr),
                  prevD ? 32'(100 + k) : 32'd20);
    end
    @(negedge clk);
    applyStimulus(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    #1;
    checkOutput("arb_last_i_rvalid", 32'(i_rvalid), 32'd1);
    checkOutput("arb_last_i_rdata", i_rdata, preload(20));
`ifdef MEM_ARB_PERF_EN
    checkOutput("perf_d_acc", perf_d_acc, 32'd6);
    checkOutput("perf_i_stall", perf_i_stall, 32'd6);
`endif

    // Store to 10, then load 10 on the very next cycle
    @(negedge clk);
    applyStimulus(1'b0, 10'd0, 1'b1, 1'b1, 10'd10, 32'h12345678);
    #1;
    checkOutput("st_d_gnt", 32'(d_gnt), 32'd1);
    checkOutput("st_mem_we", 32'(mem_we), 32'd1);
    checkOutput("st_mem_addr", 32'(mem_addr), 32'd10);
    checkOutput("st_mem_wdata", mem_wdata, 32'h12345678);
    @(negedge clk);
    applyStimulus(1'b0, 10'd0, 1'b1, 1'b0, 10'd10, 32'd0);
    #1;
    checkOutput("st_no_rvalid", 32'(d_rvalid), 32'd0);
    checkOutput("ld_d_gnt", 32'(d_gnt), 32'd1);
    checkOutput("ld_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    #1;
    checkOutput("ld_d_rvalid", 32'(d_rvalid), 32'd1);
    checkOutput("ld_d_rdata", d_rdata, 32'h12345678);

    // Reset lands on a granted fetch before its response can appear
    @(negedge clk);
    applyStimulus(1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'd0);
    #1;
    checkOutput("rf_i_gnt", 32'(i_gnt), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rf_gnt_in_rst", 32'(i_gnt), 32'd0);
    checkOutput("rf_en_in_rst", 32'(mem_en), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rf_i_rvalid_rst", 32'(i_rvalid), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rf_i_rvalid_post", 32'(i_rvalid), 32'd0);
    applyStimulus(1'b1, 10'd7, 1'b0, 1'b0, 10'd0, 32'd0);
    #1;
    checkOutput("rf_refetch_gnt", 32'(i_gnt), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    #1;
    checkOutput("rf_refetch_rvalid", 32'(i_rvalid), 32'd1);
    checkOutput("rf_refetch_rdata", i_rdata, preload(7));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
